load_store_unit: RTL and testbench

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

---
 rtl/lsu_pkg.sv | 36 +++
 rtl/lsu_lane_align.sv | 43 ++++
 rtl/load_store_unit.sv | 139 +++++++++++++
 tb/tb_load_store_unit.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: RV32I funct3 codes,
// FSM state type and the request legality check.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACCESS,
    ST_MERGE_WR,
    ST_RESP
  } lsu_state_t;

  // A request is in error when funct3 is illegal for its direction or the
  // address is not naturally aligned for the access size.
  function automatic logic req_is_err(input logic       we,
                                      input logic [2:0] funct3,
                                      input logic [1:0] addr_lo);
    logic err;
    err = 1'b1;
    unique case (funct3)
      F3_B:    err = 1'b0;
      F3_H:    err = addr_lo[0];
      F3_W:    err = (addr_lo != 2'b00);
      F3_BU:   err = we;
      F3_HU:   err = we | addr_lo[0];
      default: err = 1'b1;
    endcase
    return err;
  endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Combinational lane logic: extracts and extends a load lane from a memory
// word, and builds a store word by replacing one lane with new data.
module lsu_lane_align
  import lsu_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic [2:0]       i_funct3,
  input  logic [1:0]       i_addr_lo,
  input  logic [WIDTH-1:0] i_word,
  input  logic [WIDTH-1:0] i_wdata,
  output logic [WIDTH-1:0] o_load_data,
  output logic [WIDTH-1:0] o_merge_word
);

  logic [WIDTH-1:0] w_shifted;

  assign w_shifted = i_word >> {i_addr_lo, 3'b000};

  // Load path: right-justify the addressed lane, then sign or zero extend.
  always_comb begin
    o_load_data = '0;
    unique case (i_funct3)
      F3_B:    o_load_data = {{(WIDTH-8){w_shifted[7]}}, w_shifted[7:0]};
      F3_BU:   o_load_data = {{(WIDTH-8){1'b0}}, w_shifted[7:0]};
      F3_H:    o_load_data = {{(WIDTH-16){w_shifted[15]}}, w_shifted[15:0]};
      F3_HU:   o_load_data = {{(WIDTH-16){1'b0}}, w_shifted[15:0]};
      F3_W:    o_load_data = i_word;
      default: o_load_data = '0;
    endcase
  end

  // Store path: keep the captured word and overwrite only the addressed lane.
  always_comb begin
    o_merge_word = i_word;
    unique case (i_funct3)
      F3_B:    o_merge_word[{i_addr_lo, 3'b000} +: 8]        = i_wdata[7:0];
      F3_H:    o_merge_word[{i_addr_lo[1], 4'b0000} +: 16]  = i_wdata[15:0];
      default: o_merge_word = i_word;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Single-outstanding load/store unit between a core request port and a
// word-addressed data memory with combinational read data. Sub-word stores
// are done as read-modify-write.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_we,
  input  logic [2:0]       req_funct3,
  input  logic [WIDTH-1:0] req_addr,
  input  logic [WIDTH-1:0] req_wdata,
  output logic             rsp_valid,
  output logic [WIDTH-1:0] rsp_rdata,
  output logic             rsp_err,
  output logic             mem_we,
  output logic [WIDTH-1:0] mem_addr,
  output logic [WIDTH-1:0] mem_wd,
  input  logic [WIDTH-1:0] mem_rd
);

  lsu_state_t       r_state;
  lsu_state_t       w_next;
  logic             r_we;
  logic [2:0]       r_funct3;
  logic [WIDTH-1:0] r_addr;
  logic [WIDTH-1:0] r_wdata;
  logic [WIDTH-1:0] r_merge;
  logic [WIDTH-1:0] r_rdata;
  logic             r_err;

  logic             w_accept;
  logic             w_req_err;
  logic             w_is_sw;
  logic [WIDTH-1:0] w_align_word;
  logic [WIDTH-1:0] w_load_data;
  logic [WIDTH-1:0] w_merge_word;
  logic [WIDTH-1:0] w_word_addr;

  assign w_accept    = req_valid && (r_state == ST_IDLE);
  assign w_req_err   = req_is_err(req_we, req_funct3, req_addr[1:0]);
  assign w_is_sw     = r_we && (r_funct3 == F3_W);
  assign w_word_addr = {r_addr[WIDTH-1:2], 2'b00};

  // One aligner serves both phases: live memory data while reading, the
  // captured word while writing back the merge.
  assign w_align_word = (r_state == ST_MERGE_WR) ? r_merge : mem_rd;

  lsu_lane_align #(
    .WIDTH (WIDTH)
  ) u_lane_align (
    .i_funct3     (r_funct3),
    .i_addr_lo    (r_addr[1:0]),
    .i_word       (w_align_word),
    .i_wdata      (r_wdata),
    .o_load_data  (w_load_data),
    .o_merge_word (w_merge_word)
  );

  // State register; reset returns to IDLE, which drops mem_we at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_next;
  end

  // Next-state and Moore outputs; memory port is quiet outside ACCESS/MERGE_WR.
  always_comb begin
    w_next    = r_state;
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    rsp_rdata = '0;
    rsp_err   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wd    = '0;
    unique case (r_state)
      ST_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) w_next = w_req_err ? ST_RESP : ST_ACCESS;
      end
      ST_ACCESS: begin
        mem_addr = w_word_addr;
        if (w_is_sw) begin
          mem_we = 1'b1;
          mem_wd = r_wdata;
          w_next = ST_RESP;
        end else if (r_we) begin
          w_next = ST_MERGE_WR;
        end else begin
          w_next = ST_RESP;
        end
      end
      ST_MERGE_WR: begin
        mem_addr = w_word_addr;
        mem_we   = 1'b1;
        mem_wd   = w_merge_word;
        w_next   = ST_RESP;
      end
      ST_RESP: begin
        rsp_valid = 1'b1;
        rsp_rdata = r_rdata;
        rsp_err   = r_err;
        w_next    = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  // Request latch at acceptance, then load result or merge word in ACCESS.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_we     <= 1'b0;
      r_funct3 <= '0;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_merge  <= '0;
      r_rdata  <= '0;
      r_err    <= 1'b0;
    end else begin
      if (w_accept) begin
        r_we     <= req_we;
        r_funct3 <= req_funct3;
        r_addr   <= req_addr;
        r_wdata  <= req_wdata;
        r_err    <= w_req_err;
        r_rdata  <= '0;
      end
      if (r_state == ST_ACCESS) begin
        if (!r_we) r_rdata <= w_load_data;
        else       r_merge <= mem_rd;
      end
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit with a behavioural word memory.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wd;
  logic [31:0] mem_rd;

  load_store_unit #(.WIDTH(32)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_rdata  (rsp_rdata),
    .rsp_err    (rsp_err),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wd     (mem_wd),
    .mem_rd     (mem_rd)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int unsigned acc;
    int unsigned lat;
  } exp_t;

  exp_t        sb_q[$];
  logic [31:0] mem     [0:1023];
  logic [31:0] ref_mem [0:1023];
  int unsigned cyc = 0;
  int unsigned n_cmp = 0;
  int unsigned n_err = 0;
  int unsigned we_cnt = 0;
  int unsigned addr_cnt = 0;

  function automatic logic [31:0] init_word(input int unsigned i);
    return (32'h9E3779B9 * (i + 1)) ^ (i << 7);
  endfunction

  assign mem_rd = mem[mem_addr[11:2]];

  // Behavioural memory: preload once, then write on mem_we.
  initial begin
    for (int unsigned i = 0; i < 1024; i++) mem[i] = init_word(i);
    mem[32'h40] = 32'h8899AABB;
    forever begin
      @(posedge clk);
      if (mem_we) mem[mem_addr[11:2]] <= mem_wd;
    end
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic ref_err(input logic we, input logic [2:0] f3, input logic [31:0] a);
    case (f3)
      3'b000:  return 1'b0;
      3'b001:  return a[0];
      3'b010:  return a[1:0] != 2'b00;
      3'b100:  return we;
      3'b101:  return we | a[0];
      default: return 1'b1;
    endcase
  endfunction

  function automatic logic [31:0] ref_load(input logic [31:0] w, input logic [2:0] f3, input logic [31:0] a);
    logic [31:0] s;
    s = w >> (8 * a[1:0]);
    case (f3)
      3'b000:  return {{24{s[7]}}, s[7:0]};
      3'b100:  return {24'h0, s[7:0]};
      3'b001:  return {{16{s[15]}}, s[15:0]};
      3'b101:  return {16'h0, s[15:0]};
      default: return w;
    endcase
  endfunction

  // Response monitor: pops the scoreboard on each rsp_valid cycle.
  always @(negedge clk) begin
    exp_t e;
    if (mem_we) we_cnt++;
    if (mem_addr != 32'h0) addr_cnt++;
    if (rst_n && rsp_valid) begin
      check("resp_mem_quiet", {29'h0, mem_we, |mem_addr, |mem_wd}, 32'h0);
      if (sb_q.size() == 0) begin
        check("unexpected_rsp", 32'h1, 32'h0);
      end else begin
        e = sb_q.pop_front();
        check("rsp_rdata", rsp_rdata, e.rdata);
        check("rsp_err", {31'h0, rsp_err}, {31'h0, e.err});
        check("latency", cyc - e.acc, e.lat);
      end
    end
  end

  // Drives a request and leaves req_valid high after the accepting edge.
  task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] wd, output int unsigned acc);
    exp_t        e;
    int unsigned n;
    logic [31:0] mask;
    int unsigned idx;
    @(negedge clk);
    req_valid  = 1'b1;
    req_we     = we;
    req_funct3 = f3;
    req_addr   = a;
    req_wdata  = wd;
    n = 0;
    while (!req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    acc = cyc;
    if (!req_ready) begin
      check("accept_timeout", 32'h0, 32'h1);
      req_valid = 1'b0;
      return;
    end
    idx     = 32'(a[11:2]);
    e.acc   = cyc;
    e.err   = ref_err(we, f3, a);
    e.lat   = e.err ? 1 : ((!we || f3 == 3'b010) ? 2 : 3);
    e.rdata = (e.err || we) ? 32'h0 : ref_load(ref_mem[idx], f3, a);
    sb_q.push_back(e);
    if (we && !e.err) begin
      mask = (f3 == 3'b000) ? 32'hFF : (f3 == 3'b001) ? 32'hFFFF : 32'hFFFF_FFFF;
      mask = mask << (8 * a[1:0]);
      ref_mem[idx] = (ref_mem[idx] & ~mask) | ((wd << (8 * a[1:0])) & mask);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int unsigned n;
    n = 0;
    while (sb_q.size() != 0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    check("drain", sb_q.size(), 32'h0);
  endtask

  initial begin
    int unsigned acc, acc2, we0, ad0, rel, n;
    for (int unsigned i = 0; i < 1024; i++) ref_mem[i] = init_word(i);
    ref_mem[32'h40] = 32'h8899AABB;
    rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0;
    req_funct3 = 3'b0; req_addr = '0; req_wdata = '0;

    repeat (2) @(negedge clk);
    check("rst_ready", {31'h0, req_ready}, 32'h1);
    check("rst_rsp_valid", {31'h0, rsp_valid}, 32'h0);
    check("rst_rsp_rdata", rsp_rdata, 32'h0);
    check("rst_rsp_err", {31'h0, rsp_err}, 32'h0);
    check("rst_mem_port", {31'h0, mem_we} | mem_addr | mem_wd, 32'h0);
    @(posedge clk); #1 rst_n = 1'b1;

    // Loads from the reference word, both extensions.
    issue(1'b0, 3'b000, 32'h101, 32'h0, acc); req_valid = 1'b0;
    issue(1'b0, 3'b100, 32'h101, 32'h0, acc); req_valid = 1'b0;
    issue(1'b0, 3'b001, 32'h102, 32'h0, acc); req_valid = 1'b0;
    issue(1'b0, 3'b101, 32'h102, 32'h0, acc); req_valid = 1'b0;
    issue(1'b0, 3'b010, 32'h100, 32'h0, acc); req_valid = 1'b0;
    drain();

    // Byte read-modify-write.
    issue(1'b1, 3'b000, 32'h102, 32'h12, acc); req_valid = 1'b0;
    drain();
    check("sb_mem", mem[32'h40], 32'h8812AABB);

    // Full-word store then readback.
    we0 = we_cnt;
    issue(1'b1, 3'b010, 32'h204, 32'hDEADBEEF, acc); req_valid = 1'b0;
    drain();
    check("sw_we_cycles", we_cnt - we0, 32'h1);
    issue(1'b0, 3'b010, 32'h204, 32'h0, acc); req_valid = 1'b0;
    drain();

    // Errors: misaligned and illegal funct3 never touch memory.
    we0 = we_cnt; ad0 = addr_cnt;
    issue(1'b0, 3'b010, 32'h102, 32'h0, acc); req_valid = 1'b0;
    issue(1'b1, 3'b001, 32'h203, 32'h77, acc); req_valid = 1'b0;
    issue(1'b0, 3'b011, 32'h200, 32'h0, acc); req_valid = 1'b0;
    issue(1'b1, 3'b100, 32'h200, 32'h55, acc); req_valid = 1'b0;
    issue(1'b0, 3'b101, 32'h101, 32'h0, acc); req_valid = 1'b0;
    drain();
    check("err_we_cycles", we_cnt - we0, 32'h0);
    check("err_addr_cycles", addr_cnt - ad0, 32'h0);
    check("err_mem_kept", mem[32'h81], 32'hDEADBEEF);

    // Random mix over a small window.
    for (int i = 0; i < 30; i++) begin
      issue(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
            32'h300 + 32'($urandom_range(0, 63)), $urandom, acc);
      req_valid = 1'b0;
    end
    drain();
    for (int unsigned i = 32'hC0; i < 32'hD0; i++) check("rand_mem", mem[i], ref_mem[i]);

    // req_valid held high across two loads.
    issue(1'b0, 3'b010, 32'h204, 32'h0, acc);
    issue(1'b0, 3'b010, 32'h100, 32'h0, acc2);
    req_valid = 1'b0;
    check("b2b_spacing", acc2 - acc, 32'h3);
    drain();

    // Reset during MERGE_WR of a halfword store.
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b001;
    req_addr = 32'h100; req_wdata = 32'h5555;
    @(posedge clk); #1 req_valid = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!mem_we && n < 10);
    check("merge_seen", {31'h0, mem_we}, 32'h1);
    #1 rst_n = 1'b0;
    #1;
    check("rst_async_we", {31'h0, mem_we}, 32'h0);
    check("rst_async_ready", {31'h0, req_ready}, 32'h1);
    repeat (2) @(posedge clk);
    #1;
    check("rst_mem_kept", mem[32'h40], 32'h8812AABB);
    rst_n = 1'b1;
    rel = cyc;
    issue(1'b0, 3'b010, 32'h100, 32'h0, acc); req_valid = 1'b0;
    check("post_rst_accept", acc, rel);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
